trigger_generator: RTL and testbench

//  Periodic exposure-trigger source for the camera/strobe path, in the systemClock domain.

---
 rtl/trigger_generator_if.sv | 20 ++
 rtl/trigger_generator.sv | 201 ++++++++++++++++++++
 tb/tb_trigger_generator.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/trigger_generator_if.sv
// Custom-instruction bus between the CPU and the trigger generator.
interface trigger_generator_if;
    logic        ciStart;
    logic        ciCke;
    logic [7:0]  ciN;
    logic [31:0] ciValueA;
    logic [31:0] ciValueB;
    logic [31:0] ciResult;
    logic        ciDone;

    modport master (
        output ciStart, ciCke, ciN, ciValueA, ciValueB,
        input  ciResult, ciDone
    );

    modport slave (
        input  ciStart, ciCke, ciN, ciValueA, ciValueB,
        output ciResult, ciDone
    );
endinterface

// File: rtl/trigger_generator.sv
// Periodic exposure-trigger source (continuous or N-pulse burst), configured over the CI bus.
// Optional TRIGGER_GEN_EXT_SYNC_EN: pulses are started by rising edges of an external frame sync.
module trigger_generator #(
    parameter logic [7:0] CUSTOM_INSTRUCTION_ID = 8'd0,
    parameter int         CNT_NBITS             = 32
) (
    input  logic                systemClock,
    input  logic                reset,
    trigger_generator_if.slave  ci,
    output logic                trigger,
    output logic                busy
`ifdef TRIGGER_GEN_EXT_SYNC_EN
    ,
    input  logic                extSync
`endif
);

    localparam logic [1:0] IDLE  = 2'b00;
    localparam logic [1:0] PULSE = 2'b01;
    localparam logic [1:0] GAP   = 2'b10;
    localparam logic [1:0] ARMED = 2'b11;

    localparam logic [2:0] CMD_START      = 3'd0;
    localparam logic [2:0] CMD_STOP       = 3'd1;
    localparam logic [2:0] CMD_SET_PERIOD = 3'd2;
    localparam logic [2:0] CMD_SET_WIDTH  = 3'd3;
    localparam logic [2:0] CMD_GET_STATUS = 3'd4;
    localparam logic [2:0] CMD_GET_FRAMES = 3'd5;

`ifdef TRIGGER_GEN_EXT_SYNC_EN
    localparam bit EXT_SYNC = 1'b1;
`else
    localparam bit EXT_SYNC = 1'b0;
`endif

    typedef logic [CNT_NBITS-1:0] cnt_t;

    function automatic cnt_t clampPeriod(input cnt_t p);
        if (p < CNT_NBITS'(2)) clampPeriod = CNT_NBITS'(2);
        else                   clampPeriod = p;
    endfunction

    // Width is forced into [1, pEff-1] so every period has a high and a low cycle.
    function automatic cnt_t clampWidth(input cnt_t w, input cnt_t pEff);
        cnt_t wMin;
        if (w == CNT_NBITS'(0)) wMin = CNT_NBITS'(1);
        else                    wMin = w;
        if (wMin >= pEff) clampWidth = pEff - CNT_NBITS'(1);
        else              clampWidth = wMin;
    endfunction

    logic [1:0] state_r;
    logic [1:0] stateNext_s;
    cnt_t       period_r, width_r, pEff_r, wEff_r, cnt_r, frameCount_r, remaining_r;
    logic       continuous_r;
    logic       sel_s, cmdValid_s, start_s, stop_s, enterPulse_s, more_s, extEdge_s;
    logic [2:0] cmd_s;
    cnt_t       argB_s, pEffNext_s, wEffNext_s;

    assign sel_s      = ci.ciStart & ci.ciCke & (ci.ciN == CUSTOM_INSTRUCTION_ID);
    assign cmdValid_s = sel_s & (ci.ciValueA[31:3] == 29'd0);
    assign cmd_s      = ci.ciValueA[2:0];
    assign start_s    = cmdValid_s & (cmd_s == CMD_START);
    assign stop_s     = cmdValid_s & (cmd_s == CMD_STOP);
    assign argB_s     = ci.ciValueB[CNT_NBITS-1:0];
    assign pEffNext_s = clampPeriod(period_r);
    assign wEffNext_s = clampWidth(width_r, pEffNext_s);
    assign ci.ciDone  = sel_s;

`ifdef TRIGGER_GEN_EXT_SYNC_EN
    logic [2:0] syncChain_r;
    logic       edge_r;

    // Two-flop synchroniser, then a registered rising-edge detect.
    always_ff @(posedge systemClock) begin
        if (reset) begin
            syncChain_r <= 3'b000;
            edge_r      <= 1'b0;
        end else begin
            syncChain_r <= {syncChain_r[1:0], extSync};
            edge_r      <= syncChain_r[1] & ~syncChain_r[2];
        end
    end
    assign extEdge_s = edge_r;
`else
    assign extEdge_s = 1'b0;
`endif

    // CI read mux; reads return zero unless this block is addressed with a valid code.
    always_comb begin
        ci.ciResult = 32'd0;
        if (cmdValid_s) begin
            case (cmd_s)
                CMD_GET_STATUS: ci.ciResult = {29'd0, state_r, busy};
                CMD_GET_FRAMES: ci.ciResult = 32'(frameCount_r);
                default:        ci.ciResult = 32'd0;
            endcase
        end else begin
            ci.ciResult = 32'd0;
        end
    end

    // Next-state logic: STOP beats START, both beat the period-end transition.
    always_comb begin
        more_s       = continuous_r | (remaining_r != CNT_NBITS'(0));
        enterPulse_s = 1'b0;
        stateNext_s  = state_r;
        if (stop_s) begin
            stateNext_s = IDLE;
        end else if (start_s) begin
            if (EXT_SYNC) begin
                stateNext_s = ARMED;
            end else begin
                stateNext_s  = PULSE;
                enterPulse_s = 1'b1;
            end
        end else begin
            case (state_r)
                IDLE: stateNext_s = IDLE;
                PULSE: begin
                    if (cnt_r == wEff_r) stateNext_s = GAP;
                    else                 stateNext_s = PULSE;
                end
                GAP: begin
                    if (extEdge_s && more_s) begin
                        stateNext_s  = PULSE;
                        enterPulse_s = 1'b1;
                    end else if (cnt_r == pEff_r) begin
                        if (!more_s) begin
                            stateNext_s = IDLE;
                        end else if (EXT_SYNC) begin
                            stateNext_s = ARMED;
                        end else begin
                            stateNext_s  = PULSE;
                            enterPulse_s = 1'b1;
                        end
                    end else begin
                        stateNext_s = GAP;
                    end
                end
                ARMED: begin
                    if (extEdge_s) begin
                        stateNext_s  = PULSE;
                        enterPulse_s = 1'b1;
                    end else begin
                        stateNext_s = ARMED;
                    end
                end
                default: stateNext_s = IDLE;
            endcase
        end
    end

    // FSM, period counter and burst/frame bookkeeping; pEff/wEff only change at pulse entry.
    always_ff @(posedge systemClock) begin
        if (reset) begin
            state_r      <= IDLE;
            trigger      <= 1'b0;
            busy         <= 1'b0;
            pEff_r       <= CNT_NBITS'(2);
            wEff_r       <= CNT_NBITS'(1);
            cnt_r        <= CNT_NBITS'(0);
            frameCount_r <= CNT_NBITS'(0);
            remaining_r  <= CNT_NBITS'(0);
            continuous_r <= 1'b0;
        end else begin
            state_r <= stateNext_s;
            trigger <= (stateNext_s == PULSE);
            busy    <= (stateNext_s != IDLE);
            if (enterPulse_s) begin
                pEff_r <= pEffNext_s;
                wEff_r <= wEffNext_s;
                cnt_r  <= CNT_NBITS'(1);
            end else begin
                cnt_r  <= cnt_r + CNT_NBITS'(1);
            end
            if (start_s) begin
                continuous_r <= (argB_s == CNT_NBITS'(0));
                remaining_r  <= EXT_SYNC ? argB_s : argB_s - CNT_NBITS'(1);
                frameCount_r <= enterPulse_s ? CNT_NBITS'(1) : CNT_NBITS'(0);
            end else if (enterPulse_s) begin
                frameCount_r <= frameCount_r + CNT_NBITS'(1);
                if (!continuous_r && (remaining_r != CNT_NBITS'(0))) begin
                    remaining_r <= remaining_r - CNT_NBITS'(1);
                end
            end
        end
    end

    // Configuration registers written by SET_PERIOD / SET_WIDTH.
    always_ff @(posedge systemClock) begin
        if (reset) begin
            period_r <= CNT_NBITS'(1000);
            width_r  <= CNT_NBITS'(10);
        end else begin
            if (cmdValid_s && (cmd_s == CMD_SET_PERIOD)) period_r <= argB_s;
            if (cmdValid_s && (cmd_s == CMD_SET_WIDTH))  width_r  <= argB_s;
        end
    end

endmodule

// File: tb/tb_trigger_generator.sv
// Directed bench for trigger_generator: vector table of period/width patterns plus
// hand-written sequences for bursts, shadowed period writes, STOP, reset and ext sync.
module tb_trigger_generator;

    logic systemClock;
    logic reset;
    logic trigger;
    logic busy;
    int   nTests;
    int   nFail;

    trigger_generator_if bus ();

`ifdef TRIGGER_GEN_EXT_SYNC_EN
    logic extSync;
    trigger_generator #(.CUSTOM_INSTRUCTION_ID(8'd0), .CNT_NBITS(32)) dut (
        .systemClock(systemClock), .reset(reset), .ci(bus),
        .trigger(trigger), .busy(busy), .extSync(extSync));
`else
    trigger_generator #(.CUSTOM_INSTRUCTION_ID(8'd0), .CNT_NBITS(32)) dut (
        .systemClock(systemClock), .reset(reset), .ci(bus),
        .trigger(trigger), .busy(busy));
`endif

    initial systemClock = 1'b0;
    always #5 systemClock = ~systemClock;

    typedef struct {
        logic [31:0] period;
        logic [31:0] width;
        int          high;
        int          low;
        int          cycles;
        logic [31:0] frames;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nTests++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Called just after a falling edge; returns one cycle later, just after the next falling edge.
    task automatic ciOp(input logic [31:0] a, input logic [31:0] b, output logic [31:0] res);
        bus.ciStart  = 1'b1;
        bus.ciCke    = 1'b1;
        bus.ciN      = 8'd0;
        bus.ciValueA = a;
        bus.ciValueB = b;
        #1;
        res = bus.ciResult;
        chk("ciDone", {31'd0, bus.ciDone}, 32'd1);
        @(negedge systemClock);
        bus.ciStart  = 1'b0;
        bus.ciValueA = 32'd0;
        bus.ciValueB = 32'd0;
    endtask

    task automatic ciRead(input string name, input logic [31:0] a, input logic [31:0] exp);
        logic [31:0] r;
        ciOp(a, 32'd0, r);
        chk(name, r, exp);
    endtask

    task automatic ciWrite(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] r;
        ciOp(a, b, r);
    endtask

    initial begin
        logic [31:0] r;
        nTests = 0;
        nFail  = 0;
        reset  = 1'b1;
        bus.ciStart = 1'b0; bus.ciCke = 1'b0; bus.ciN = 8'd0;
        bus.ciValueA = 32'd0; bus.ciValueB = 32'd0;
`ifdef TRIGGER_GEN_EXT_SYNC_EN
        extSync = 1'b0;
`endif
        //                period  width  high low cycles frames
        vecs[0] = '{32'd8,  32'd3,  3, 5, 72, 32'd10};
        vecs[1] = '{32'd5,  32'd2,  2, 3, 10, 32'd3};
        vecs[2] = '{32'd7,  32'd0,  1, 6, 14, 32'd3};
        vecs[3] = '{32'd6,  32'd20, 5, 1, 12, 32'd3};
        vecs[4] = '{32'd1,  32'd1,  1, 1,  4, 32'd3};
        vecs[5] = '{32'd0,  32'd0,  1, 1,  4, 32'd3};
        vecs[6] = '{32'd2,  32'd5,  1, 1,  4, 32'd3};
        vecs[7] = '{32'd3,  32'd3,  2, 1,  6, 32'd3};

        repeat (3) @(negedge systemClock);
        chk("rst_trigger", {31'd0, trigger}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        reset = 1'b0;
        @(negedge systemClock);
        ciRead("rst_status", 32'd4, 32'd0);
        ciRead("rst_frames", 32'd5, 32'd0);
        chk("rst_trigger_idle", {31'd0, trigger}, 32'd0);

`ifndef TRIGGER_GEN_EXT_SYNC_EN
        // Reset defaults: period 1000, width 10.
        ciWrite(32'd0, 32'd0);
        for (int i = 0; i < 12; i++) begin
            chk("dflt_width", {31'd0, trigger}, (i < 10) ? 32'd1 : 32'd0);
            @(negedge systemClock);
        end
        ciWrite(32'd1, 32'd0);

        for (int v = 0; v < 8; v++) begin
            ciWrite(32'd2, vecs[v].period);
            ciWrite(32'd3, vecs[v].width);
            ciWrite(32'd0, 32'd0);
            for (int i = 0; i < vecs[v].cycles; i++) begin
                chk($sformatf("vec%0d_trig_c%0d", v, i), {31'd0, trigger},
                    ((i % (vecs[v].high + vecs[v].low)) < vecs[v].high) ? 32'd1 : 32'd0);
                @(negedge systemClock);
            end
            ciRead($sformatf("vec%0d_frames", v), 32'd5, vecs[v].frames);
            ciWrite(32'd1, 32'd0);
            chk($sformatf("vec%0d_stop_trig", v), {31'd0, trigger}, 32'd0);
            chk($sformatf("vec%0d_stop_busy", v), {31'd0, busy}, 32'd0);
        end

        // Burst of 3, period 5, width 2: busy drops at cycle 16 after START.
        ciWrite(32'd2, 32'd5);
        ciWrite(32'd3, 32'd2);
        ciWrite(32'd0, 32'd3);
        for (int k = 1; k <= 20; k++) begin
            chk($sformatf("burst_trig_k%0d", k), {31'd0, trigger},
                ((k <= 15) && (((k - 1) % 5) < 2)) ? 32'd1 : 32'd0);
            chk($sformatf("burst_busy_k%0d", k), {31'd0, busy}, (k <= 15) ? 32'd1 : 32'd0);
            @(negedge systemClock);
        end
        ciRead("burst_frames", 32'd5, 32'd3);
        ciRead("burst_status", 32'd4, 32'd0);

        // Period write mid-period is shadowed; STOP mid-pulse drops trigger next cycle.
        ciWrite(32'd2, 32'd10);
        ciWrite(32'd3, 32'd2);
        ciWrite(32'd0, 32'd0);
        for (int k = 1; k <= 3; k++) begin
            chk($sformatf("shadow_k%0d", k), {31'd0, trigger}, (k <= 2) ? 32'd1 : 32'd0);
            @(negedge systemClock);
        end
        chk("shadow_k4", {31'd0, trigger}, 32'd0);
        ciWrite(32'd2, 32'd4);
        chk("shadow_k5", {31'd0, trigger}, 32'd0);
        ciRead("status_gap", 32'd4, 32'd5);
        for (int k = 6; k <= 10; k++) begin
            chk($sformatf("shadow_k%0d", k), {31'd0, trigger}, 32'd0);
            @(negedge systemClock);
        end
        chk("shadow_k11", {31'd0, trigger}, 32'd1);
        ciRead("status_pulse", 32'd4, 32'd3);
        for (int k = 12; k <= 18; k++) begin
            chk($sformatf("shadow_k%0d", k), {31'd0, trigger},
                ((k == 12) || (k == 15) || (k == 16)) ? 32'd1 : 32'd0);
            @(negedge systemClock);
        end
        chk("shadow_k19", {31'd0, trigger}, 32'd1);
        ciWrite(32'd1, 32'd0);
        chk("stop_mid_trig", {31'd0, trigger}, 32'd0);
        chk("stop_mid_busy", {31'd0, busy}, 32'd0);
        ciRead("stop_status", 32'd4, 32'd0);

        // Malformed / reserved / foreign-ID commands.
        ciRead("reserved6", 32'd6, 32'd0);
        ciRead("bad_high_bits", 32'h0000_000D, 32'd0);
        bus.ciStart = 1'b1; bus.ciCke = 1'b1; bus.ciN = 8'd5; bus.ciValueA = 32'd5;
        #1;
        chk("foreign_done", {31'd0, bus.ciDone}, 32'd0);
        chk("foreign_result", bus.ciResult, 32'd0);
        @(negedge systemClock);
        bus.ciStart = 1'b0; bus.ciN = 8'd0; bus.ciValueA = 32'd0;

        // Reset mid-run returns everything to defaults.
        ciWrite(32'd0, 32'd0);
        repeat (7) @(negedge systemClock);
        reset = 1'b1;
        @(negedge systemClock);
        reset = 1'b0;
        chk("midrst_trig", {31'd0, trigger}, 32'd0);
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        ciRead("midrst_frames", 32'd5, 32'd0);
        ciRead("midrst_status", 32'd4, 32'd0);
`else
        // External sync: one 3-cycle pulse four edges after each sync edge.
        ciWrite(32'd2, 32'd100);
        ciWrite(32'd3, 32'd3);
        ciWrite(32'd0, 32'd0);
        chk("armed_trig", {31'd0, trigger}, 32'd0);
        ciRead("armed_status", 32'd4, 32'd7);
        for (int e = 0; e < 2; e++) begin
            extSync = 1'b1;
            for (int j = 0; j < 10; j++) begin
                @(negedge systemClock);
                chk($sformatf("ext%0d_j%0d", e, j), {31'd0, trigger},
                    ((j >= 3) && (j <= 5)) ? 32'd1 : 32'd0);
            end
            extSync = 1'b0;
            repeat (40) @(negedge systemClock);
        end
        ciRead("ext_frames", 32'd5, 32'd2);
        ciWrite(32'd1, 32'd0);
        chk("ext_stop_busy", {31'd0, busy}, 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule
